// File: rtl/rr_arb_pkg.sv
// rtl/rr_arb_pkg.sv - shared types and helpers for the round-robin decoder arbiter
// Contents:
//   arb_state_e : arbiter FSM states (idle, owner granted, break-before-make gap)
//   onehot_m    : index to one-hot mask (LSB = index 0), truncated by the caller
package rr_arb_pkg;

   typedef enum logic [1:0] {
      ARB_IDLE  = 2'd0,
      ARB_GRANT = 2'd1,
      ARB_GAP   = 2'd2
   } arb_state_e;

   function automatic logic [31:0] onehot_m(input int unsigned idx);
      return 32'd1 << idx;
   endfunction

endpackage

// File: rtl/decoder_m2n_high_v2.sv
// rtl/decoder_m2n_high_v2.sv - M-to-2**M active-high decoder with enable
// Ports:
//   a  in  M      encoded select
//   en in  1      enable; all outputs low when 0
//   y  out 2**M   one-hot select, y[a] = en
module decoder_m2n_high_v2 #(
   parameter int M = 2
) (
   input  logic [M-1:0]      a,
   input  logic              en,
   output logic [(2**M)-1:0] y
);

   localparam int N = 2**M;

   always_comb begin
      y = '0;
      if (en) begin
         y[a] = 1'b1;
      end
   end

endmodule

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational rotating-priority picker
// Ports:
//   req  in  2**M  request vector
//   ptr  in  M     highest-priority index; priority falls ptr, ptr+1, ... mod 2**M
//   pick out M     first requesting index in that order (0 when none)
//   any  out 1     at least one request present
module rr_pick #(
   parameter int M = 2
) (
   input  logic [(2**M)-1:0] req,
   input  logic [M-1:0]      ptr,
   output logic [M-1:0]      pick,
   output logic              any
);

   localparam int N = 2**M;

   logic [M-1:0] idx;

   // Scan from the farthest offset back to ptr so the nearest requester
   // overwrites the others; the M-bit add wraps modulo N for free.
   always_comb begin
      pick = '0;
      any  = 1'b0;
      idx  = '0;
      for (int k = N - 1; k >= 0; k--) begin
         idx = ptr + M'(k);
         if (req[idx]) begin
            pick = idx;
            any  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/rr_decoder_arbiter.sv
// rtl/rr_decoder_arbiter.sv - round-robin arbiter driving a shared decoder select bus
// Ports:
//   clk        in  1  system clock, rising edge
//   rst_n      in  1  asynchronous active-low reset
//   req        in  N  level request per requester, held until done
//   gnt_valid  out 1  a grant is active (decoder enable)
//   gnt_idx    out M  index of current or last owner
//   gnt_onehot out N  decoded grant, zero outside a tenure
//   busy       out 1  arbiter not idle
module rr_decoder_arbiter
   import rr_arb_pkg::*;
#(
   parameter int M        = 2,
   parameter int N        = 2**M,
   parameter int MAX_HOLD = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [N-1:0] req,
   output logic         gnt_valid,
   output logic [M-1:0] gnt_idx,
   output logic [N-1:0] gnt_onehot,
   output logic         busy
);

   localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
   localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

   arb_state_e    state, state_n;
   logic [M-1:0]  ptr, ptr_n;
   logic [M-1:0]  gnt_idx_n;
   logic [HW-1:0] hold_cnt, hold_cnt_n;

   logic [M-1:0]  pick_ptr;
   logic [M-1:0]  pick;
   logic          any;
   logic          contended;

   // In GAP the search already starts just past the outgoing owner, the same
   // value ptr takes on the way out of GAP.
   assign pick_ptr = (state == ARB_GAP) ? (gnt_idx + M'(1)) : ptr;

   rr_pick #(.M(M)) u_pick (
      .req  (req),
      .ptr  (pick_ptr),
      .pick (pick),
      .any  (any)
   );

   assign contended = |(req & ~N'(onehot_m(32'(gnt_idx))));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ARB_IDLE;
         gnt_idx  <= '0;
         ptr      <= '0;
         hold_cnt <= '0;
      end else begin
         state    <= state_n;
         gnt_idx  <= gnt_idx_n;
         ptr      <= ptr_n;
         hold_cnt <= hold_cnt_n;
      end
   end

   always_comb begin
      state_n    = state;
      gnt_idx_n  = gnt_idx;
      ptr_n      = ptr;
      hold_cnt_n = hold_cnt;
      case (state)
         ARB_IDLE: begin
            if (any) begin
               state_n    = ARB_GRANT;
               gnt_idx_n  = pick;
               hold_cnt_n = '0;
            end
         end
         ARB_GRANT: begin
            // Release and preemption both funnel into the same single GAP.
            if (!req[gnt_idx] || ((hold_cnt == HOLD_LAST) && contended)) begin
               state_n = ARB_GAP;
            end else if (hold_cnt != HOLD_LAST) begin
               hold_cnt_n = hold_cnt + HW'(1);
            end
         end
         ARB_GAP: begin
            ptr_n = gnt_idx + M'(1);
            if (any) begin
               state_n    = ARB_GRANT;
               gnt_idx_n  = pick;
               hold_cnt_n = '0;
            end else begin
               state_n = ARB_IDLE;
            end
         end
         default: begin
            state_n = ARB_IDLE;
         end
      endcase
   end

   // Outputs come from registered state only, so reset drops them at once
   // and req has no combinational path to the select bus.
   assign gnt_valid = (state == ARB_GRANT);
   assign busy      = (state != ARB_IDLE);

   decoder_m2n_high_v2 #(.M(M)) u_dec (
      .a  (gnt_idx),
      .en (gnt_valid),
      .y  (gnt_onehot)
   );

endmodule

// File: tb/tb_rr_decoder_arbiter.sv
// tb/tb_rr_decoder_arbiter.sv - directed self-checking bench for rr_decoder_arbiter
module tb_rr_decoder_arbiter;
   import rr_arb_pkg::*;

   localparam int M        = 2;
   localparam int N        = 4;
   localparam int MAX_HOLD = 4;

   logic         clk;
   logic         rst_n;
   logic [N-1:0] req;
   logic         gnt_valid;
   logic [M-1:0] gnt_idx;
   logic [N-1:0] gnt_onehot;
   logic         busy;

   int total;
   int bad;

   rr_decoder_arbiter #(.M(M), .N(N), .MAX_HOLD(MAX_HOLD)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req        (req),
      .gnt_valid  (gnt_valid),
      .gnt_idx    (gnt_idx),
      .gnt_onehot (gnt_onehot),
      .busy       (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic pulse_reset();
      @(negedge clk);
      rst_n = 1'b0;
      req   = 4'b0000;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      @(negedge clk);
      total++;
      if ({gnt_valid, gnt_onehot, busy, gnt_idx} !== 8'b0) begin
         bad++;
         $display("FAIL reset_state got v=%b oh=%b busy=%b idx=%0d exp all zero", gnt_valid, gnt_onehot, busy, gnt_idx);
      end
      rst_n = 1'b1;
      req = 4'b0001;
      @(negedge clk);
      total++;
      if (gnt_onehot !== 4'b0001 || gnt_valid !== 1'b1) begin
         bad++;
         $display("FAIL reset_pre_grant got v=%b oh=%b exp v=1 oh=0001", gnt_valid, gnt_onehot);
      end
      #2 rst_n = 1'b0;
      #1;
      total++;
      if (gnt_valid !== 1'b0 || gnt_onehot !== 4'b0000 || busy !== 1'b0) begin
         bad++;
         $display("FAIL reset_async_drop got v=%b oh=%b busy=%b exp 0 0000 0", gnt_valid, gnt_onehot, busy);
      end
      @(negedge clk);
      req = 4'b0000;
      rst_n = 1'b1;
      repeat (2) begin
         @(negedge clk);
         total++;
         if (busy !== 1'b0 || gnt_onehot !== 4'b0000) begin
            bad++;
            $display("FAIL reset_stays_idle got busy=%b oh=%b exp 0 0000", busy, gnt_onehot);
         end
      end
   endtask

   task automatic test_single();
      @(negedge clk);
      req = 4'b0100;
      @(negedge clk);
      total++;
      if (gnt_idx !== 2'd2 || gnt_onehot !== 4'b0100 || gnt_valid !== 1'b1) begin
         bad++;
         $display("FAIL single_grant got idx=%0d oh=%b v=%b exp 2 0100 1", gnt_idx, gnt_onehot, gnt_valid);
      end
      req = 4'b0000;
      @(negedge clk);
      total++;
      if (gnt_onehot !== 4'b0000 || busy !== 1'b1) begin
         bad++;
         $display("FAIL single_gap got oh=%b busy=%b exp 0000 1", gnt_onehot, busy);
      end
      @(negedge clk);
      total++;
      if (busy !== 1'b0 || gnt_idx !== 2'd2) begin
         bad++;
         $display("FAIL single_idle got busy=%b idx=%0d exp 0 2", busy, gnt_idx);
      end
   endtask

   task automatic test_full_contention();
      logic [N-1:0] exp_oh;
      pulse_reset();
      req = 4'b1111;
      for (int j = 0; j < 5; j++) begin
         for (int c = 0; c <= MAX_HOLD; c++) begin
            exp_oh = (c < MAX_HOLD) ? N'(onehot_m(j % N)) : 4'b0000;
            @(negedge clk);
            total++;
            if (gnt_onehot !== exp_oh) begin
               bad++;
               $display("FAIL contention owner=%0d cyc=%0d got=%b exp=%b", j % N, c, gnt_onehot, exp_oh);
            end
            total++;
            if ($countones(gnt_onehot) > 1) begin
               bad++;
               $display("FAIL contention_multihot got=%b exp at most one bit", gnt_onehot);
            end
         end
      end
      req = 4'b0000;
      @(negedge clk);
      total++;
      if (busy !== 1'b0) begin
         bad++;
         $display("FAIL contention_idle got busy=%b exp 0", busy);
      end
   endtask

   task automatic test_uncontended_hold();
      @(negedge clk);
      req = 4'b0001;
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         total++;
         if (gnt_onehot !== 4'b0001) begin
            bad++;
            $display("FAIL uncontended cyc=%0d got=%b exp=0001", c, gnt_onehot);
         end
      end
      req = 4'b0000;
      repeat (2) @(negedge clk);
      total++;
      if (busy !== 1'b0) begin
         bad++;
         $display("FAIL uncontended_idle got busy=%b exp 0", busy);
      end
   endtask

   task automatic test_wrap();
      @(negedge clk);
      req = 4'b0100;
      @(negedge clk);
      total++;
      if (gnt_idx !== 2'd2 || gnt_onehot !== 4'b0100) begin
         bad++;
         $display("FAIL wrap_owner2 got idx=%0d oh=%b exp 2 0100", gnt_idx, gnt_onehot);
      end
      req = 4'b0001;
      @(negedge clk);
      total++;
      if (gnt_onehot !== 4'b0000 || busy !== 1'b1) begin
         bad++;
         $display("FAIL wrap_gap got oh=%b busy=%b exp 0000 1", gnt_onehot, busy);
      end
      @(negedge clk);
      total++;
      if (gnt_idx !== 2'd0 || gnt_onehot !== 4'b0001) begin
         bad++;
         $display("FAIL wrap_owner0 got idx=%0d oh=%b exp 0 0001", gnt_idx, gnt_onehot);
      end
      req = 4'b0000;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_drop_preempt();
      pulse_reset();
      req = 4'b0011;
      for (int c = 0; c < MAX_HOLD; c++) begin
         @(negedge clk);
         total++;
         if (gnt_onehot !== 4'b0001) begin
            bad++;
            $display("FAIL droppre_owner0 cyc=%0d got=%b exp=0001", c, gnt_onehot);
         end
      end
      req = 4'b0010;
      @(negedge clk);
      total++;
      if (gnt_onehot !== 4'b0000 || busy !== 1'b1) begin
         bad++;
         $display("FAIL droppre_gap got oh=%b busy=%b exp 0000 1", gnt_onehot, busy);
      end
      for (int c = 0; c < MAX_HOLD; c++) begin
         @(negedge clk);
         total++;
         if (gnt_onehot !== 4'b0010 || gnt_idx !== 2'd1) begin
            bad++;
            $display("FAIL droppre_owner1 cyc=%0d got oh=%b idx=%0d exp 0010 1", c, gnt_onehot, gnt_idx);
         end
      end
      req = 4'b0000;
      repeat (2) @(negedge clk);
      total++;
      if (busy !== 1'b0) begin
         bad++;
         $display("FAIL droppre_idle got busy=%b exp 0", busy);
      end
   endtask

   initial begin
      total = 0;
      bad   = 0;
      rst_n = 1'b0;
      req   = 4'b0000;
      test_reset();
      test_single();
      test_full_contention();
      test_uncontended_hold();
      test_wrap();
      test_drop_preempt();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
